// File: rtl/block_sram_writer_pkg.sv
// Shared types for the DP-RAM to SRAM block write-back engine.
package block_sram_writer_pkg;

   typedef enum logic [2:0] {
      S_BW_IDLE,
      S_BW_LEAD0,
      S_BW_LEAD1,
      S_BW_W0,
      S_BW_W1,
      S_BW_W2,
      S_BW_W3,
      S_BW_DONE
   } bw_state_t;

   typedef enum logic [1:0] {
      CH_Y = 2'd0,
      CH_U = 2'd1,
      CH_V = 2'd2
   } channel_t;

   // Row down-counter load value: eight rows per block, terminal count at zero.
   localparam logic [2:0] LAST_ROW_CNT = 3'd7;

   // One DP-RAM word carries four samples, lowest index in the top byte.
   // The upper half is SRAM word 2h, the lower half SRAM word 2h+1.
   function automatic logic [15:0] sample_pair(input logic [31:0] word, input logic second_half);
      return second_half ? word[15:0] : word[31:16];
   endfunction

endpackage

// File: rtl/block_sram_writer_addr_gen.sv
// Block position tracking (column, row, channel) and SRAM raster address
// generation for the block currently being written.
module block_addr_gen
   import block_sram_writer_pkg::*;
#(
   parameter int Y_WIDTH    = 320,
   parameter int UV_WIDTH   = 160,
   parameter int IMG_HEIGHT = 240,
   parameter int Y_BASE     = 0,
   parameter int U_BASE     = 38400,
   parameter int V_BASE     = 57600,
   parameter int SRAM_AW    = 18
)(
   input  logic               Clock_50,
   input  logic               resetn,
   input  logic               advance,
   input  logic [2:0]         row_idx,
   input  logic [1:0]         word_idx,
   output logic [SRAM_AW-1:0] SRAM_address,
   output logic               last_block_of_frame,
   output channel_t           channel
);

   localparam logic [SRAM_AW-1:0] Y_ROW_WORDS  = SRAM_AW'(Y_WIDTH / 2);
   localparam logic [SRAM_AW-1:0] UV_ROW_WORDS = SRAM_AW'(UV_WIDTH / 2);
   localparam logic [SRAM_AW-1:0] Y_BLK_COLS   = SRAM_AW'(Y_WIDTH / 8);
   localparam logic [SRAM_AW-1:0] UV_BLK_COLS  = SRAM_AW'(UV_WIDTH / 8);
   localparam logic [SRAM_AW-1:0] BLK_ROWS     = SRAM_AW'(IMG_HEIGHT / 8);
   localparam logic [SRAM_AW-1:0] Y_SEG        = SRAM_AW'(Y_BASE);
   localparam logic [SRAM_AW-1:0] U_SEG        = SRAM_AW'(U_BASE);
   localparam logic [SRAM_AW-1:0] V_SEG        = SRAM_AW'(V_BASE);
   localparam logic [SRAM_AW-1:0] ONE          = SRAM_AW'(1);

   logic [SRAM_AW-1:0] block_col;
   logic [SRAM_AW-1:0] block_row;
   logic [SRAM_AW-1:0] row_words;
   logic [SRAM_AW-1:0] blk_cols;
   logic [SRAM_AW-1:0] seg_base;
   logic [SRAM_AW-1:0] line;
   logic               last_col;
   logic               last_row;

   // Geometry of the channel currently being written.
   always_comb begin
      row_words = UV_ROW_WORDS;
      blk_cols  = UV_BLK_COLS;
      seg_base  = V_SEG;
      case (channel)
         CH_Y: begin
            row_words = Y_ROW_WORDS;
            blk_cols  = Y_BLK_COLS;
            seg_base  = Y_SEG;
         end
         CH_U:    seg_base = U_SEG;
         default: seg_base = V_SEG;
      endcase
   end

   assign last_col = (block_col == blk_cols - ONE);
   assign last_row = (block_row == BLK_ROWS - ONE);
   assign last_block_of_frame = last_col && last_row && (channel == CH_V);

   // Raster address: image line of this sample row times the line stride, plus
   // the block's horizontal word offset and the word within the block row.
   always_comb begin
      line = (block_row << 3) + {{(SRAM_AW-3){1'b0}}, row_idx};
      SRAM_address = seg_base + line * row_words + (block_col << 2)
                   + {{(SRAM_AW-2){1'b0}}, word_idx};
   end

   // Step to the next block in raster order, wrapping through Y, U, V.
   always_ff @(posedge Clock_50 or negedge resetn) begin
      if (!resetn) begin
         block_col <= '0;
         block_row <= '0;
         channel   <= CH_Y;
      end else if (advance) begin
         if (last_col) begin
            block_col <= '0;
            if (last_row) begin
               block_row <= '0;
               case (channel)
                  CH_Y:    channel <= CH_U;
                  CH_U:    channel <= CH_V;
                  default: channel <= CH_Y;
               endcase
            end else begin
               block_row <= block_row + ONE;
            end
         end else begin
            block_col <= block_col + ONE;
         end
      end
   end

endmodule

// File: rtl/block_sram_writer.sv
// Drains one 8x8 block of 8-bit samples from the DP-RAM into external SRAM,
// two samples per SRAM word, sequencing Y, U and V blocks across a frame.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_BW_IDLE  | waiting for start; bank latched on acceptance
// S_BW_LEAD0 | row-0 h0 address on the DP-RAM
// S_BW_LEAD1 | row-0 h1 address on the DP-RAM; h0 data arriving
// S_BW_W0    | write k0 from h0; h1 data arriving on row 0
// S_BW_W1    | write k1 from h0; next row's h0 address on the DP-RAM
// S_BW_W2    | write k2 from h1; next row's h1 address; next h0 arriving
// S_BW_W3    | write k3 from h1; next h1 arriving; loop or finish
// S_BW_DONE  | pulse block_done, advance block position
module block_sram_writer
   import block_sram_writer_pkg::*;
#(
   parameter int Y_WIDTH    = 320,
   parameter int UV_WIDTH   = 160,
   parameter int IMG_HEIGHT = 240,
   parameter int Y_BASE     = 0,
   parameter int U_BASE     = 38400,
   parameter int V_BASE     = 57600,
   parameter int SRAM_AW    = 18,
   parameter int DP_AW      = 7
)(
   input  logic               Clock_50,
   input  logic               resetn,
   input  logic               start,
   input  logic               dp_bank,
   output logic [DP_AW-1:0]   DP_RAM_Address,
   input  logic [31:0]        DP_RAM_Read_Data,
   output logic [SRAM_AW-1:0] SRAM_address,
   output logic [15:0]        SRAM_write_data,
   output logic               SRAM_we,
   output logic               busy,
   output logic               block_done,
   output logic               frame_done,
   output logic [1:0]         channel
);

   localparam logic [DP_AW-1:0] BANK1_BASE = DP_AW'(64);

   bw_state_t          state;
   bw_state_t          state_nxt;
   logic [2:0]         rows_left;
   logic [2:0]         row_idx;
   logic [3:0]         next_row;
   logic               last_row;
   logic [1:0]         word_idx;
   logic [DP_AW-1:0]   dp_base;
   logic [DP_AW-1:0]   dp_addr_nxt;
   logic [DP_AW-1:0]   next_row_addr;
   logic               h0_cap;
   logic               h1_cap;
   logic               wr_en;
   logic [15:0]        wr_data;
   logic               advance;
   logic [31:0]        h0_word;
   logic [31:0]        h1_word;
   logic [SRAM_AW-1:0] gen_address;
   logic               last_block;
   channel_t           gen_channel;

   assign row_idx       = LAST_ROW_CNT - rows_left;
   assign last_row      = (rows_left == 3'd0);
   assign next_row      = {1'b0, row_idx} + 4'd1;
   assign next_row_addr = dp_base + DP_AW'({next_row, 1'b0});
   assign channel       = gen_channel;

   block_addr_gen #(
      .Y_WIDTH    (Y_WIDTH),
      .UV_WIDTH   (UV_WIDTH),
      .IMG_HEIGHT (IMG_HEIGHT),
      .Y_BASE     (Y_BASE),
      .U_BASE     (U_BASE),
      .V_BASE     (V_BASE),
      .SRAM_AW    (SRAM_AW)
   ) u_addr_gen (
      .Clock_50            (Clock_50),
      .resetn              (resetn),
      .advance             (advance),
      .row_idx             (row_idx),
      .word_idx            (word_idx),
      .SRAM_address        (gen_address),
      .last_block_of_frame (last_block),
      .channel             (gen_channel)
   );

   // State register.
   always_ff @(posedge Clock_50 or negedge resetn) begin
      if (!resetn) state <= S_BW_IDLE;
      else         state <= state_nxt;
   end

   // Next state, DP-RAM address for the following cycle, capture strobes and
   // the write about to be registered. Prefetch is skipped on the last row so
   // the reads never leave the 16-word bank.
   always_comb begin
      state_nxt   = state;
      dp_addr_nxt = DP_RAM_Address;
      h0_cap      = 1'b0;
      h1_cap      = 1'b0;
      wr_en       = 1'b0;
      wr_data     = 16'd0;
      word_idx    = 2'd0;
      advance     = 1'b0;
      case (state)
         S_BW_IDLE: begin
            if (start) begin
               state_nxt   = S_BW_LEAD0;
               dp_addr_nxt = dp_bank ? BANK1_BASE : '0;
            end
         end
         S_BW_LEAD0: begin
            state_nxt   = S_BW_LEAD1;
            dp_addr_nxt = dp_base + DP_AW'(1);
         end
         S_BW_LEAD1: begin
            state_nxt = S_BW_W0;
            h0_cap    = 1'b1;
         end
         S_BW_W0: begin
            state_nxt = S_BW_W1;
            wr_en     = 1'b1;
            word_idx  = 2'd0;
            wr_data   = sample_pair(h0_word, 1'b0);
            h1_cap    = (rows_left == LAST_ROW_CNT);
            if (!last_row) dp_addr_nxt = next_row_addr;
         end
         S_BW_W1: begin
            state_nxt = S_BW_W2;
            wr_en     = 1'b1;
            word_idx  = 2'd1;
            wr_data   = sample_pair(h0_word, 1'b1);
            if (!last_row) dp_addr_nxt = next_row_addr + DP_AW'(1);
         end
         S_BW_W2: begin
            state_nxt = S_BW_W3;
            wr_en     = 1'b1;
            word_idx  = 2'd2;
            wr_data   = sample_pair(h1_word, 1'b0);
            h0_cap    = 1'b1;
         end
         S_BW_W3: begin
            state_nxt = last_row ? S_BW_DONE : S_BW_W0;
            wr_en     = 1'b1;
            word_idx  = 2'd3;
            wr_data   = sample_pair(h1_word, 1'b1);
            h1_cap    = 1'b1;
         end
         S_BW_DONE: begin
            state_nxt = S_BW_IDLE;
            advance   = 1'b1;
         end
         default: state_nxt = S_BW_IDLE;
      endcase
   end

   // Bank latch, row down-counter, DP-RAM address and the two holding words.
   always_ff @(posedge Clock_50 or negedge resetn) begin
      if (!resetn) begin
         dp_base        <= '0;
         rows_left      <= 3'd0;
         DP_RAM_Address <= '0;
         h0_word        <= 32'd0;
         h1_word        <= 32'd0;
      end else begin
         DP_RAM_Address <= dp_addr_nxt;
         if (state == S_BW_IDLE && start) begin
            dp_base   <= dp_bank ? BANK1_BASE : '0;
            rows_left <= LAST_ROW_CNT;
         end else if (state == S_BW_W3 && !last_row) begin
            rows_left <= rows_left - 3'd1;
         end
         if (h0_cap) h0_word <= DP_RAM_Read_Data;
         if (h1_cap) h1_word <= DP_RAM_Read_Data;
      end
   end

   // Registered SRAM write port and handshake outputs; address, data and
   // strobe all change on the same edge.
   always_ff @(posedge Clock_50 or negedge resetn) begin
      if (!resetn) begin
         SRAM_we         <= 1'b0;
         SRAM_address    <= '0;
         SRAM_write_data <= 16'd0;
         busy            <= 1'b0;
         block_done      <= 1'b0;
         frame_done      <= 1'b0;
      end else begin
         SRAM_we         <= wr_en;
         SRAM_address    <= wr_en ? gen_address : '0;
         SRAM_write_data <= wr_data;
         busy            <= (state_nxt != S_BW_IDLE);
         block_done      <= advance;
         frame_done      <= advance && last_block;
      end
   end

endmodule

// File: tb/tb_block_sram_writer.sv
// Directed bench for block_sram_writer with a write scoreboard and a
// registered DP-RAM model.
`timescale 1ns/1ps
module tb_block_sram_writer;

   localparam int SRAM_AW = 18;
   localparam int DP_AW   = 7;
   localparam int Y_W     = 320;
   localparam int UV_W    = 160;
   localparam int IMG_H   = 240;
   localparam int Y_SEG   = 0;
   localparam int U_SEG   = 38400;
   localparam int V_SEG   = 57600;

   typedef struct packed {
      logic [SRAM_AW-1:0] addr;
      logic [15:0]        data;
   } exp_t;

   logic               Clock_50 = 1'b0;
   logic               resetn   = 1'b0;
   logic               start    = 1'b0;
   logic               dp_bank  = 1'b0;
   logic [DP_AW-1:0]   DP_RAM_Address;
   logic [31:0]        DP_RAM_Read_Data = 32'd0;
   logic [SRAM_AW-1:0] SRAM_address;
   logic [15:0]        SRAM_write_data;
   logic               SRAM_we;
   logic               busy;
   logic               block_done;
   logic               frame_done;
   logic [1:0]         channel;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   exp_t               exp_q[$];
   logic [DP_AW-1:0]   dp_seq[$];
   logic [SRAM_AW-1:0] wr_addr[32];
   logic [15:0]        first_data;
   logic [1:0]         first_ch;
   int                 we_count;
   int                 first_we_cyc;
   int                 last_we_cyc;
   int                 done_cyc;
   logic               prev_done = 1'b0;
   logic [31:0]        cur_salt  = 32'd0;

   int m_col = 0;
   int m_row = 0;
   int m_ch  = 0;

   block_sram_writer dut (
      .Clock_50         (Clock_50),
      .resetn           (resetn),
      .start            (start),
      .dp_bank          (dp_bank),
      .DP_RAM_Address   (DP_RAM_Address),
      .DP_RAM_Read_Data (DP_RAM_Read_Data),
      .SRAM_address     (SRAM_address),
      .SRAM_write_data  (SRAM_write_data),
      .SRAM_we          (SRAM_we),
      .busy             (busy),
      .block_done       (block_done),
      .frame_done       (frame_done),
      .channel          (channel)
   );

   always #10 Clock_50 = ~Clock_50;

   always @(posedge Clock_50) cyc++;

   function automatic logic [31:0] dp_word(input logic [DP_AW-1:0] a, input logic [31:0] s);
      logic [7:0] b;
      b = {a[5:0], 2'b00};
      return {b, b + 8'd1, b + 8'd2, b + 8'd3} ^ (a[6] ? 32'hA55A_3CC3 : 32'h0) ^ s;
   endfunction

   // DP-RAM: data valid one cycle after its address.
   always @(posedge Clock_50) DP_RAM_Read_Data <= dp_word(DP_RAM_Address, cur_salt);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic int exp_addr(input int ch, input int brow, input int bcol, input int r, input int k);
      int w;
      int base;
      w    = (ch == 0) ? Y_W : UV_W;
      base = (ch == 0) ? Y_SEG : ((ch == 1) ? U_SEG : V_SEG);
      return base + (brow * 8 + r) * (w / 2) + bcol * 4 + k;
   endfunction

   task automatic push_expected(input logic bank, input logic [31:0] salt);
      exp_t        e;
      logic [31:0] w;
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 4; k++) begin
            w = dp_word(DP_AW'((bank ? 64 : 0) + 2 * r + k / 2), salt);
            e.addr = SRAM_AW'(exp_addr(m_ch, m_row, m_col, r, k));
            e.data = (k % 2 == 1) ? w[15:0] : w[31:16];
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic model_advance();
      int cols;
      cols = (m_ch == 0) ? Y_W / 8 : UV_W / 8;
      m_col++;
      if (m_col == cols) begin
         m_col = 0;
         m_row++;
         if (m_row == IMG_H / 8) begin
            m_row = 0;
            m_ch  = (m_ch + 1) % 3;
         end
      end
   endtask

   // Write monitor: pops the scoreboard on every strobe, records timing.
   always @(negedge Clock_50) begin
      exp_t e;
      if (resetn && SRAM_we) begin
         if (we_count == 0) begin
            first_we_cyc = cyc;
            first_data   = SRAM_write_data;
            first_ch     = channel;
         end
         if (we_count < 32) wr_addr[we_count] = SRAM_address;
         last_we_cyc = cyc;
         we_count++;
         check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(SRAM_address), 32'(e.addr));
            check("wr_data", 32'(SRAM_write_data), 32'(e.data));
         end
      end
      if (busy) begin
         if (dp_seq.size() == 0 || dp_seq[$] != DP_RAM_Address) dp_seq.push_back(DP_RAM_Address);
      end
      if (block_done) begin
         done_cyc = cyc;
         check("done_one_cycle", 32'(prev_done), 32'd0);
      end
      if (frame_done) check("frame_with_done", 32'(block_done), 32'd1);
      prev_done = block_done;
   end

   task automatic run_block(input logic bank, input bit stray, input logic [31:0] salt);
      int sample_cyc;
      bit seen;
      bit exp_last;
      cur_salt = salt;
      exp_last = (m_ch == 2) && (m_col == UV_W / 8 - 1) && (m_row == IMG_H / 8 - 1);
      push_expected(bank, salt);
      we_count = 0;
      done_cyc = -1;
      dp_seq.delete();
      start   = 1'b1;
      dp_bank = bank;
      @(posedge Clock_50);
      #1;
      sample_cyc = cyc;
      start = 1'b0;
      seen  = 1'b0;
      for (int n = 0; n < 80 && !seen; n++) begin
         @(negedge Clock_50);
         start = (stray && n == 10);
         if (block_done === 1'b1) seen = 1'b1;
      end
      start = 1'b0;
      #1;
      check("done_seen", 32'(seen), 32'd1);
      check("frame_done", 32'(frame_done), 32'(exp_last));
      check("we_count", 32'(we_count), 32'd32);
      check("first_we_delay", 32'(first_we_cyc - sample_cyc), 32'd3);
      // block_done 35 edges after the sampling edge: 36 cycles counting the start cycle
      check("done_delay", 32'(done_cyc - sample_cyc), 32'd35);
      check("write_span", 32'(last_we_cyc - first_we_cyc), 32'd31);
      check("channel_in_block", 32'(first_ch), 32'(m_ch));
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      model_advance();
   endtask

   initial begin
      #2_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;

      resetn = 1'b0;
      repeat (3) @(posedge Clock_50);
      #1;
      check("rst_we", 32'(SRAM_we), 32'd0);
      check("rst_addr", 32'(SRAM_address), 32'd0);
      check("rst_data", 32'(SRAM_write_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(block_done), 32'd0);
      check("rst_frame", 32'(frame_done), 32'd0);
      check("rst_channel", 32'(channel), 32'd0);
      check("rst_dp_addr", 32'(DP_RAM_Address), 32'd0);
      @(negedge Clock_50);
      resetn = 1'b1;
      @(negedge Clock_50);

      // First block, fixed DP contents, bank 0
      run_block(1'b0, 1'b0, 32'd0);
      check("b0_first_addr", 32'(wr_addr[0]), 32'd0);
      check("b0_first_data", 32'(first_data), 32'h0001);
      check("b0_row1_addr", 32'(wr_addr[4]), 32'd160);
      check("b0_last_addr", 32'(wr_addr[31]), 32'd1123);
      check("b0_dp_count", 32'(dp_seq.size()), 32'd16);
      for (int i = 0; i < 16 && i < dp_seq.size(); i++) check("b0_dp_order", 32'(dp_seq[i]), 32'(i));
      check("b0_channel_after", 32'(channel), 32'd0);

      // Remainder of the frame
      for (int b = 1; b < 2400; b++) begin
         run_block(b[0] ? 1'b1 : 1'b0, 1'b0, $urandom);
         if (b == 39)   check("b39_first_addr", 32'(wr_addr[0]), 32'd156);
         if (b == 40)   check("b40_first_addr", 32'(wr_addr[0]), 32'd1280);
         if (b == 1199) check("y_done_channel", 32'(channel), 32'd1);
         if (b == 1200) begin
            check("u0_first_addr", 32'(wr_addr[0]), 32'd38400);
            check("u0_row1_addr", 32'(wr_addr[4]), 32'd38480);
         end
         if (b == 2399) check("frame_last_addr", 32'(wr_addr[31]), 32'd76799);
      end
      check("frame_channel_wrap", 32'(channel), 32'd0);

      // Bank 1 with a stray start mid-block; counters back at Y (0,0)
      run_block(1'b1, 1'b1, $urandom);
      check("wrap_first_addr", 32'(wr_addr[0]), 32'd0);
      check("b1_dp_count", 32'(dp_seq.size()), 32'd16);
      for (int i = 0; i < 16 && i < dp_seq.size(); i++) check("b1_dp_order", 32'(dp_seq[i]), 32'(64 + i));
      repeat (5) @(negedge Clock_50);
      #1;
      check("stray_no_restart_busy", 32'(busy), 32'd0);
      check("stray_no_extra_writes", 32'(we_count), 32'd32);

      // Reset after ten writes of the next block
      cur_salt = $urandom;
      push_expected(1'b0, cur_salt);
      we_count = 0;
      start    = 1'b1;
      dp_bank  = 1'b0;
      @(posedge Clock_50);
      #1;
      start = 1'b0;
      seen  = 1'b0;
      for (int n = 0; n < 80 && !seen; n++) begin
         @(negedge Clock_50);
         #1;
         if (we_count >= 10) seen = 1'b1;
      end
      check("rst_mid_reached", 32'(seen), 32'd1);
      resetn = 1'b0;
      #1;
      check("mid_rst_we", 32'(SRAM_we), 32'd0);
      check("mid_rst_addr", 32'(SRAM_address), 32'd0);
      check("mid_rst_data", 32'(SRAM_write_data), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(block_done), 32'd0);
      check("mid_rst_channel", 32'(channel), 32'd0);
      check("mid_rst_dp_addr", 32'(DP_RAM_Address), 32'd0);
      exp_q.delete();
      m_col = 0;
      m_row = 0;
      m_ch  = 0;
      @(negedge Clock_50);
      resetn = 1'b1;
      @(negedge Clock_50);
      run_block(1'b0, 1'b0, $urandom);
      check("post_rst_first_addr", 32'(wr_addr[0]), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
